l1_mmu_arbiter: RTL
===================

Name: l1_mmu_arbiter

Overview:
- Shares the single l1mmu request port between the L1 iCache (read-only line fills) and the L1 dCache (line fills and write-backs).
- Replaces the combinational icache-first mux in the top level with a registered, locked-grant arbiter.
- Ordering is round-robin between the two caches, and each transfer is protected by a watchdog.
- Sits between fetch/l1dcache and l1mmu; each requester sees a private done/data channel.

Parameters:
- LINE_W, 256, cache line width in bits (read/write data).
- ADDR_W, 32, request address width.
- TIMEOUT, 1023, maximum BUSY cycles before the transfer is aborted; 0 disables the watchdog.

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- ic_req_read  in  1  iCache line-fill request
- ic_req_addr  in  ADDR_W  iCache request address
- ic_done  out  1  one-cycle completion pulse to iCache
- ic_read_data  out  LINE_W  line returned to iCache
- dc_req_read  in  1  dCache line-fill request
- dc_req_write  in  1  dCache write-back request
- dc_req_addr  in  ADDR_W  dCache request address
- dc_write_data  in  LINE_W  dCache write-back line
- dc_done  out  1  one-cycle completion pulse to dCache
- dc_read_data  out  LINE_W  line returned to dCache
- mmu_read  out  1  read request to l1mmu
- mmu_write  out  1  write request to l1mmu
- mmu_addr  out  ADDR_W  address to l1mmu
- mmu_write_data  out  LINE_W  write line to l1mmu
- mmu_done  in  1  l1mmu completion pulse
- mmu_read_data  in  LINE_W  l1mmu read line, valid with mmu_done
- err  out  1  sticky error: timeout or dCache read+write both high

Behaviour:
- Clock and reset: single clock sys_clk; reset rst_n is synchronous, active-low.
- Reset values: all outputs 0; state IDLE; last_owner = DC, so the iCache wins the first tie; timeout counter 0.
- FSM states are IDLE, BUSY and DONE. The owner register holds IC or DC.

IDLE:
- Samples requests.
- Only one cache requesting: that cache is granted.
- Both requesting: the cache that is not last_owner is granted.
- On grant:
  - latch the address, the write data, and the operation (IC is always a read);
  - set owner and last_owner;
  - go to BUSY.
- mmu_done while in IDLE is ignored.

BUSY:
- mmu_read/mmu_write are driven from the latched operation and held high every cycle until mmu_done.
- mmu_addr and mmu_write_data are driven from the latches and stay stable regardless of changes at the requester inputs.
- On mmu_done:
  - read: latch mmu_read_data into the owner's read_data register;
  - go to DONE; the timeout counter clears.

DONE:
- Exactly one cycle.
- The owner's done is 1; mmu_read/mmu_write are 0.
- Next state is IDLE.

Requester rule:
- Requesters hold req/addr/data stable from assertion until they see done.
- Requesters deassert req at the clock edge ending the DONE cycle.
- As a result, IDLE never re-grants a stale request.

Latency and data hold:
- Request seen in IDLE at cycle 0 gives mmu_read/mmu_write high in cycle 1.
- mmu_done in cycle k gives done high in cycle k+1.
- Minimum turnaround is 3 cycles per transfer, plus 1 IDLE cycle before the next grant.
- Each read_data register holds its value until that requester's next completed read.
- dc_read_data is not updated on writes.

dCache read and write both high at grant:
- The write takes precedence.
- err is set.

Watchdog (TIMEOUT>0):
- The counter increments each BUSY cycle.
- When the counter reaches TIMEOUT:
  - go to DONE; the owner's done pulses;
  - read_data is left unchanged;
  - err is set and mmu_read/mmu_write drop.
- err clears only on reset.

Other rules:
- No preemption: a dCache request arriving during an iCache transfer waits; it is granted in the IDLE after DONE.
- Reset asserted in any state: next cycle is IDLE with outputs zero. A pending mmu_done after reset is ignored.

Test Plan:
- Reset, then ic_req_read=1 addr 0x0000_0040; l1mmu answers done 4 cycles after mmu_read with data 0xA5..A5 -> mmu_read high cycles 1–4, mmu_addr=0x40, ic_done pulses once in cycle 5, ic_read_data=0xA5..A5, dc_done stays 0.
- ic_req_read and dc_req_read asserted together from reset, both re-requested after each completion -> grants alternate I, D, I, D; every mmu_addr matches the granted owner.
- dc_req_write addr 0x1000_0020, data 0x1234..; after grant, change dc_req_addr to 0xFFFF_FFFF -> mmu_write=1, mmu_addr stays 0x1000_0020, dc_read_data unchanged after dc_done.
- TIMEOUT=8, ic_req_read with mmu_done never asserted -> mmu_read drops after 8 BUSY cycles, ic_done pulses, err=1 and stays 1.
- dc_req_read and dc_req_write both 1 -> mmu_write=1, mmu_read=0, err=1.
- rst_n low for one cycle mid-BUSY, then mmu_done pulses -> all outputs 0, state IDLE, no done pulse, next request granted normally.

Source files
------------

// File: rtl/l1_mmu_arbiter.sv
// Registered, locked-grant round-robin arbiter that shares the single l1mmu port
// between the iCache (line fills) and the dCache (fills and write-backs), with a watchdog.
module l1_mmu_arbiter #(
  parameter int LINE_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              ic_req_read,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_done,
  output logic [LINE_W-1:0] ic_read_data,
  input  logic              dc_req_read,
  input  logic              dc_req_write,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [LINE_W-1:0] dc_write_data,
  output logic              dc_done,
  output logic [LINE_W-1:0] dc_read_data,
  output logic              mmu_read,
  output logic              mmu_write,
  output logic [ADDR_W-1:0] mmu_addr,
  output logic [LINE_W-1:0] mmu_write_data,
  input  logic              mmu_done,
  input  logic [LINE_W-1:0] mmu_read_data,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {OWN_IC, OWN_DC} owner_t;

  state_t            state_reg, state_next;
  // Owner and last owner are always written together, so one register serves both.
  owner_t            owner_reg, owner_next;
  logic              write_reg, write_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [LINE_W-1:0] wdata_reg, wdata_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              err_reg, err_next;
  logic [LINE_W-1:0] ic_data_reg, ic_data_next;
  logic [LINE_W-1:0] dc_data_reg, dc_data_next;

  logic dc_req;
  logic grant_ic;
  logic timeout_hit;

  assign dc_req      = dc_req_read || dc_req_write;
  assign grant_ic    = ic_req_read && (!dc_req || owner_reg == OWN_DC);
  assign timeout_hit = (TIMEOUT > 0) && (cnt_reg == CNT_LAST);

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      owner_reg   <= OWN_DC;
      write_reg   <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      cnt_reg     <= '0;
      err_reg     <= 1'b0;
      ic_data_reg <= '0;
      dc_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      write_reg   <= write_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      cnt_reg     <= cnt_next;
      err_reg     <= err_next;
      ic_data_reg <= ic_data_next;
      dc_data_reg <= dc_data_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    write_next   = write_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    cnt_next     = cnt_reg;
    err_next     = err_reg;
    ic_data_next = ic_data_reg;
    dc_data_next = dc_data_reg;
    case (state_reg)
      IDLE: begin
        if (ic_req_read || dc_req) begin
          state_next = BUSY;
          cnt_next   = '0;
          if (grant_ic) begin
            owner_next = OWN_IC;
            write_next = 1'b0;
            addr_next  = ic_req_addr;
          end else begin
            // A simultaneous read+write from the dCache is resolved as the write.
            owner_next = OWN_DC;
            write_next = dc_req_write;
            addr_next  = dc_req_addr;
            wdata_next = dc_write_data;
            if (dc_req_read && dc_req_write) err_next = 1'b1;
          end
        end
      end
      BUSY: begin
        if (mmu_done) begin
          state_next = DONE;
          cnt_next   = '0;
          if (!write_reg) begin
            if (owner_reg == OWN_IC) ic_data_next = mmu_read_data;
            else                     dc_data_next = mmu_read_data;
          end
        end else if (timeout_hit) begin
          state_next = DONE;
          cnt_next   = '0;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mmu_read       = (state_reg == BUSY) && !write_reg;
  assign mmu_write      = (state_reg == BUSY) && write_reg;
  assign mmu_addr       = addr_reg;
  assign mmu_write_data = wdata_reg;
  assign ic_done        = (state_reg == DONE) && (owner_reg == OWN_IC);
  assign dc_done        = (state_reg == DONE) && (owner_reg == OWN_DC);
  assign ic_read_data   = ic_data_reg;
  assign dc_read_data   = dc_data_reg;
  assign err            = err_reg;

endmodule
